// File: rtl/fetch_queue_if.sv
// Fetch/decode side bus of the instruction prefetch queue.
// slave = queue side, master = fetch/decode (or bench) side.
interface fetch_queue_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 9,
   parameter int DEPTH   = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // Handshake: a beat moves on a rising edge where valid && ready are both high;
   // valid/data must hold until accepted, and ready never depends on the partner's valid.
   logic               taken;
   logic               in_valid;
   logic               in_ready;
   logic [PC_W-1:0]    pc_i;
   logic [INSTR_W-1:0] instr_i;
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    pc_o;
   logic [INSTR_W-1:0] instr_o;
   logic [CNT_W-1:0]   count_o;

   modport slave (
      input  taken, in_valid, pc_i, instr_i, out_ready,
      output in_ready, out_valid, pc_o, instr_o, count_o
   );

   modport master (
      output taken, in_valid, pc_i, instr_i, out_ready,
      input  in_ready, out_valid, pc_o, instr_o, count_o
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode, flushed by a taken branch.
// Define FQ_BYPASS_EN to let an empty queue pass the input straight to the output.
module fetch_queue #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 9,
   parameter int DEPTH   = 4
) (
   input logic           f_clk,
   input logic           start,
   fetch_queue_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = PC_W + INSTR_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ENT_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_stored_valid;
   logic             w_bypass;
   logic             w_bypass_take;
   logic             w_push;
   logic             w_pop;
   logic [ENT_W-1:0] w_head;

   assign w_stored_valid = (r_count != '0);
   assign w_head         = r_mem[r_rd_ptr];

`ifdef FQ_BYPASS_EN
   // Reset and flush both kill the pass-through so no wrong-path word escapes.
   assign w_bypass = !w_stored_valid && bus.in_valid && !bus.taken && !start;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_bypass_take = w_bypass && bus.out_ready;
   assign w_push        = bus.in_valid && bus.in_ready && !w_bypass_take;
   assign w_pop         = w_stored_valid && bus.out_ready;

   assign bus.in_ready = (r_count != FULL_CNT);
   assign bus.count_o  = r_count;

   always_comb begin
      bus.out_valid = w_stored_valid;
      bus.pc_o      = '0;
      bus.instr_o   = '0;
      if (w_stored_valid) begin
         {bus.pc_o, bus.instr_o} = w_head;
      end else if (w_bypass) begin
         bus.out_valid = 1'b1;
         bus.pc_o      = bus.pc_i;
         bus.instr_o   = bus.instr_i;
      end
   end

   always_ff @(posedge f_clk) begin
      if (start || bus.taken) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.pc_i, bus.instr_i};
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios followed by random traffic.
module tb_fetch_queue;
   localparam int PC_W    = 8;
   localparam int INSTR_W = 9;
   localparam int DEPTH   = 4;
   localparam int ENT_W   = PC_W + INSTR_W;

   logic f_clk = 1'b0;
   logic start;

   always #5 f_clk = ~f_clk;

   fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

   fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .f_clk (f_clk),
      .start (start),
      .bus   (bus)
   );

   // Reference contents of the queue, oldest entry at index 0.
   logic [ENT_W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   bit done  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic tk, input logic iv,
                        input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                        input logic ordy);
      @(posedge f_clk);
      #1;
      start         = st;
      bus.taken     = tk;
      bus.in_valid  = iv;
      bus.pc_i      = pc;
      bus.instr_i   = ins;
      bus.out_ready = ordy;
   endtask

   // Monitor: compare outputs mid-cycle, then advance the reference for the coming edge.
   initial begin
      logic             e_ov;
      logic [PC_W-1:0]  e_pc;
      logic [INSTR_W-1:0] e_ins;
      int               sz;
      bit               byp;
      @(posedge f_clk);
      forever begin
         @(negedge f_clk);
         if (done) break;
         sz    = exp_q.size();
         byp   = 1'b0;
`ifdef FQ_BYPASS_EN
         byp   = (sz == 0) && bus.in_valid && !bus.taken && !start;
`endif
         e_ov  = (sz != 0) || byp;
         e_pc  = '0;
         e_ins = '0;
         if (sz != 0) {e_pc, e_ins} = exp_q[0];
         else if (byp) begin
            e_pc  = bus.pc_i;
            e_ins = bus.instr_i;
         end
         check("count_o",   32'(bus.count_o),   32'(sz));
         check("in_ready",  32'(bus.in_ready),  32'(sz != DEPTH));
         check("out_valid", 32'(bus.out_valid), 32'(e_ov));
         check("pc_o",      32'(bus.pc_o),      32'(e_pc));
         check("instr_o",   32'(bus.instr_o),   32'(e_ins));

         if (start || bus.taken) begin
            exp_q.delete();
         end else if (!(byp && bus.out_ready)) begin
            if (sz != 0 && bus.out_ready) void'(exp_q.pop_front());
            if (bus.in_valid && sz != DEPTH) exp_q.push_back({bus.pc_i, bus.instr_i});
         end
      end
   end

   initial begin
      logic [PC_W-1:0] r_pc;
      logic            iv;
      start         = 1'b1;
      bus.taken     = 1'b0;
      bus.in_valid  = 1'b1;
      bus.pc_i      = 8'h33;
      bus.instr_i   = 9'h1aa;
      bus.out_ready = 1'b0;

      // Reset held for two edges while fetch offers a word.
      drive(1, 0, 1, 8'h34, 9'h1ab, 0);

      // Fill to full, offer a fifth word, then drain.
      for (int i = 0; i < 5; i++) drive(0, 0, 1, PC_W'(i), INSTR_W'(9'h101 + i), 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 8'h00, 9'h000, 1);

      // Steady push/pop at occupancy 2 across pointer wrap.
      drive(0, 0, 1, 8'h20, 9'h020, 0);
      drive(0, 0, 1, 8'h21, 9'h021, 0);
      for (int i = 0; i < 10; i++) drive(0, 0, 1, PC_W'(8'h22 + i), INSTR_W'(9'h022 + i), 1);
      for (int i = 0; i < 2; i++) drive(0, 0, 0, 8'h00, 9'h000, 1);

      // Flush with a push presented, then refill.
      for (int i = 1; i < 4; i++) drive(0, 0, 1, PC_W'(i), INSTR_W'(9'h100 + i), 0);
      drive(0, 1, 1, 8'h05, 9'h105, 0);
      drive(0, 0, 1, 8'h05, 9'h105, 0);
      drive(0, 0, 0, 8'h00, 9'h000, 0);
      drive(0, 1, 0, 8'h00, 9'h000, 1);
      drive(0, 1, 1, 8'h06, 9'h106, 0);

      // Reset beats flush and push in the same cycle.
      drive(0, 0, 1, 8'h07, 9'h107, 0);
      drive(1, 1, 1, 8'h08, 9'h108, 1);
      drive(0, 0, 0, 8'h00, 9'h000, 0);

      // Empty queue offered a word with decode ready.
      drive(0, 0, 1, 8'h10, 9'h110, 1);
      drive(0, 0, 0, 8'h00, 9'h000, 1);
      drive(0, 0, 0, 8'h00, 9'h000, 1);

      // Random traffic with occasional flushes and resets.
      r_pc = 8'h40;
      for (int i = 0; i < 400; i++) begin
         iv = ($urandom_range(0, 3) != 0);
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0), iv,
               r_pc, INSTR_W'($urandom_range(0, 511)), ($urandom_range(0, 2) != 0));
         if (iv) r_pc = r_pc + 8'h01;
      end
      drive(0, 0, 0, 8'h00, 9'h000, 1);

      @(posedge f_clk);
      #1;
      done = 1'b1;
      @(negedge f_clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
